// File: rtl/afe_pkg.sv
// rtl/afe_pkg.sv - shared register map, control bit positions and frame FSM encoding for the AFE SPI slave
package afe_pkg;

  localparam int REG_WIDTH    = 24;
  localparam int ADDR_WIDTH   = 8;
  localparam int FRAME_BITS   = ADDR_WIDTH + REG_WIDTH;
  localparam int NUM_ADC_REGS = 6;

  localparam logic [7:0] ADDR_CONTROL0  = 8'h00;
  localparam logic [7:0] ADDR_CONTROL1  = 8'h1E;
  localparam logic [7:0] ADDR_ADC_FIRST = 8'h2A;
  localparam logic [7:0] ADDR_ADC_LAST  = 8'h2F;

  localparam int BIT_SPI_READ = 0;
  localparam int BIT_SW_RST   = 3;
  localparam int BIT_TIMEREN  = 8;

  localparam logic [REG_WIDTH-1:0] SW_RST_MASK = REG_WIDTH'(1) << BIT_SW_RST;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  function automatic logic is_adc_addr(input logic [7:0] addr);
    return (addr >= ADDR_ADC_FIRST) && (addr <= ADDR_ADC_LAST);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - two-flop synchronizer with rise/fall detection on the synchronized level
module spi_sync_edge #(
  parameter logic IDLE_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= IDLE_VAL;
      sync_q <= IDLE_VAL;
      prev_q <= IDLE_VAL;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level = sync_q;
  assign rise  = sync_q & ~prev_q;
  assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/afe_spi_slave.sv
// rtl/afe_spi_slave.sv - oversampled SPI register slave with read-back shifter and conversion-ready timer
module afe_spi_slave import afe_pkg::*; #(
  parameter int PRF_DIV = 4000,
  parameter int NREG    = 50
) (
  input  logic         div_clk,
  input  logic         rst,
  input  logic         sclk,
  input  logic         spiste,
  input  logic         spisimo,
  output logic         spisomi,
  input  logic [143:0] adc_regs,
  output logic         adc_rdy,
  output logic         wr_strobe,
  output logic [7:0]   wr_addr,
  output logic [23:0]  wr_data
);

  localparam int CNT_W = (PRF_DIV > 1) ? $clog2(PRF_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRF_DIV - 1);
  localparam int IDX_CTL0 = int'(ADDR_CONTROL0);
  localparam int IDX_CTL1 = int'(ADDR_CONTROL1);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi, mosi_rise, mosi_fall;

  spi_sync_edge #(.IDLE_VAL(1'b0)) u_sync_sclk (
    .clk(div_clk), .rst(rst), .din(sclk),
    .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.IDLE_VAL(1'b1)) u_sync_cs (
    .clk(div_clk), .rst(rst), .din(spiste),
    .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync_edge #(.IDLE_VAL(1'b0)) u_sync_mosi (
    .clk(div_clk), .rst(rst), .din(spisimo),
    .level(mosi), .rise(mosi_rise), .fall(mosi_fall)
  );

  logic unused_sync;
  assign unused_sync = &{1'b0, sclk_lvl, cs_rise, mosi_rise, mosi_fall};

  logic [1:0]           state;
  logic [5:0]           bit_cnt;
  logic [FRAME_BITS-2:0] shift_q;
  logic [REG_WIDTH-1:0] tx_q;
  logic                 rd_active;
  logic [REG_WIDTH-1:0] regs [NREG];
  logic [CNT_W-1:0]     cnt;

  logic [FRAME_BITS-1:0] frame;
  logic [7:0]            frame_addr;
  logic [7:0]            hdr_addr;
  logic [REG_WIDTH-1:0]  frame_data;
  logic [REG_WIDTH-1:0]  rd_value;
  logic spi_read, timeren;
  logic hdr_end, frame_end, accept, commit;

  // frame is the shift register as it will look once the current sampled bit is folded in
  assign frame      = {shift_q, mosi};
  assign frame_addr = frame[FRAME_BITS-1 -: ADDR_WIDTH];
  assign frame_data = frame[REG_WIDTH-1:0];
  assign hdr_addr   = frame[ADDR_WIDTH-1:0];

  assign spi_read = regs[IDX_CTL0][BIT_SPI_READ];
  assign timeren  = regs[IDX_CTL1][BIT_TIMEREN];

  assign hdr_end   = (state == ST_ADDR) && !cs_lvl && sclk_rise && (bit_cnt == 6'd7);
  assign frame_end = (state == ST_DATA) && !cs_lvl && sclk_rise && (bit_cnt == 6'd31);
  assign accept    = (frame_addr == ADDR_CONTROL0) ||
                     (!spi_read && !is_adc_addr(frame_addr) && (32'(frame_addr) < NREG));
  assign commit    = frame_end && accept;

  always_comb begin
    rd_value = '0;
    if (is_adc_addr(hdr_addr)) begin
      for (int i = 0; i < NUM_ADC_REGS; i++) begin
        if (hdr_addr == ADDR_ADC_FIRST + 8'(i)) rd_value = adc_regs[i*REG_WIDTH +: REG_WIDTH];
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (hdr_addr == 8'(i)) rd_value = regs[i];
      end
    end
  end

  always_ff @(posedge div_clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shift_q   <= '0;
      tx_q      <= '0;
      rd_active <= 1'b0;
      spisomi   <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      wr_strobe <= 1'b0;
      if (cs_fall) begin
        state     <= ST_ADDR;
        bit_cnt   <= '0;
        shift_q   <= '0;
        tx_q      <= '0;
        rd_active <= 1'b0;
        spisomi   <= 1'b0;
      end else if (cs_lvl && (state != ST_IDLE)) begin
        // chip select released: a short frame is simply dropped here
        state     <= ST_IDLE;
        rd_active <= 1'b0;
        spisomi   <= 1'b0;
      end else begin
        case (state)
          ST_ADDR: begin
            if (sclk_rise) begin
              shift_q <= frame[FRAME_BITS-2:0];
              bit_cnt <= bit_cnt + 6'd1;
              if (hdr_end) begin
                state <= ST_DATA;
                if (spi_read) begin
                  tx_q      <= rd_value;
                  rd_active <= 1'b1;
                end
              end
            end
          end
          ST_DATA: begin
            if (sclk_rise) begin
              shift_q <= frame[FRAME_BITS-2:0];
              bit_cnt <= bit_cnt + 6'd1;
              if (frame_end) begin
                state     <= ST_DONE;
                rd_active <= 1'b0;
                spisomi   <= 1'b0;
                if (commit) begin
                  wr_strobe <= 1'b1;
                  wr_addr   <= frame_addr;
                  wr_data   <= frame_data;
                end
              end
            end else if (sclk_fall && rd_active) begin
              spisomi <= tx_q[REG_WIDTH-1];
              tx_q    <= {tx_q[REG_WIDTH-2:0], 1'b0};
            end
          end
          default: ;
        endcase
      end
    end
  end

  // SW_RST wipes the map, but the CONTROL0 value carried by the same write survives
  always_ff @(posedge div_clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (commit) begin
      if ((frame_addr == ADDR_CONTROL0) && frame_data[BIT_SW_RST]) begin
        for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end
      for (int i = 0; i < NREG; i++) begin
        if (frame_addr == 8'(i)) regs[i] <= (i == IDX_CTL0) ? (frame_data & ~SW_RST_MASK) : frame_data;
      end
    end
  end

  always_ff @(posedge div_clk) begin
    if (rst || !timeren) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign adc_rdy = timeren && (cnt == CNT_LAST);

endmodule

// File: tb/tb_afe_spi_slave.sv
// tb/tb_afe_spi_slave.sv - randomized self-checking bench for afe_spi_slave against a register-map model
`timescale 1ns/1ps
module tb_afe_spi_slave;

  logic         div_clk = 1'b0;
  logic         rst = 1'b1;
  logic         sclk = 1'b0;
  logic         spiste = 1'b1;
  logic         spisimo = 1'b0;
  logic         spisomi;
  logic [143:0] adc_regs;
  logic         adc_rdy;
  logic         wr_strobe;
  logic [7:0]   wr_addr;
  logic [23:0]  wr_data;

  logic [23:0] adc_arr [6];
  logic [23:0] mreg [50];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int strobe_cnt = 0;
  int strobe_cyc = 0;
  int rdy_q[$];

  assign adc_regs = {adc_arr[5], adc_arr[4], adc_arr[3], adc_arr[2], adc_arr[1], adc_arr[0]};

  afe_spi_slave #(.PRF_DIV(10), .NREG(50)) dut (
    .div_clk(div_clk), .rst(rst), .sclk(sclk), .spiste(spiste), .spisimo(spisimo),
    .spisomi(spisomi), .adc_regs(adc_regs), .adc_rdy(adc_rdy),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 div_clk = ~div_clk;

  always @(negedge div_clk) begin
    cyc = cyc + 1;
    if (wr_strobe === 1'b1) begin
      strobe_cnt = strobe_cnt + 1;
      strobe_cyc = cyc;
    end
    if (adc_rdy === 1'b1) rdy_q.push_back(cyc);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge div_clk);
    #1;
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 50; i++) mreg[i] = '0;
  endfunction

  function automatic logic model_accept(input logic [7:0] a);
    if (a == 8'h00) return 1'b1;
    if (mreg[0][0]) return 1'b0;
    if (a >= 8'h2A && a <= 8'h2F) return 1'b0;
    return int'(a) < 50;
  endfunction

  function automatic logic [23:0] model_read(input logic [7:0] a);
    if (a >= 8'h2A && a <= 8'h2F) return adc_arr[int'(a) - 42];
    if (int'(a) < 50) return mreg[int'(a)];
    return 24'h0;
  endfunction

  function automatic void model_commit(input logic [7:0] a, input logic [23:0] d);
    if (a == 8'h00) begin
      if (d[3]) model_clear();
      mreg[0] = d & ~24'h000008;
    end else begin
      mreg[int'(a)] = d;
    end
  endfunction

  // Mode-0 master: data set up while sclk is low, sampled by both sides on the rising edge
  task automatic do_frame(input logic [7:0] a, input logic [23:0] d, input int nbits,
                          input int rst_bit, output logic [31:0] rx);
    logic [31:0] txw;
    txw = {a, d};
    rx = '0;
    spiste = 1'b0;
    tick(5);
    for (int i = 0; i < nbits; i++) begin
      spisimo = txw[31-i];
      tick(5);
      rx[31-i] = spisomi;
      if (i == rst_bit) begin
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
      end
      sclk = 1'b1;
      tick(5);
      sclk = 1'b0;
    end
    tick(5);
    spiste = 1'b1;
    spisimo = 1'b0;
    tick(8);
  endtask

  task automatic xfer(input string tag, input logic [7:0] a, input logic [23:0] d);
    logic [31:0] rx;
    logic [23:0] exp_rd;
    logic        acc;
    int          s0;
    exp_rd = mreg[0][0] ? model_read(a) : 24'h0;
    acc = model_accept(a);
    s0 = strobe_cnt;
    do_frame(a, d, 32, -1, rx);
    check($sformatf("%s_strobe", tag), strobe_cnt - s0, {31'h0, acc});
    if (acc) begin
      check($sformatf("%s_addr", tag), {24'h0, wr_addr}, {24'h0, a});
      check($sformatf("%s_data", tag), {8'h0, wr_data}, {8'h0, d});
      model_commit(a, d);
    end
    check($sformatf("%s_miso", tag), rx, {8'h0, exp_rd});
    check($sformatf("%s_idle", tag), {31'h0, spisomi}, 32'h0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [31:0] rx;
    logic [7:0]  a;
    logic [23:0] d;
    int          s0;
    int          sc;
    int          sel;

    for (int i = 0; i < 6; i++) adc_arr[i] = 24'($urandom);
    adc_arr[2] = 24'hFEDCBA;
    model_clear();

    rst = 1'b1;
    tick(5);
    check("rst_spisomi", {31'h0, spisomi}, 32'h0);
    check("rst_adc_rdy", {31'h0, adc_rdy}, 32'h0);
    check("rst_wr_strobe", {31'h0, wr_strobe}, 32'h0);
    check("rst_wr_addr", {24'h0, wr_addr}, 32'h0);
    check("rst_wr_data", {8'h0, wr_data}, 32'h0);
    rst = 1'b0;
    tick(4);

    xfer("w01", 8'h01, 24'h00ABCD);
    xfer("ctl_rd", 8'h00, 24'h000001);
    xfer("rd01", 8'h01, 24'h000000);
    xfer("w02_blocked", 8'h02, 24'h123456);
    xfer("rd02", 8'h02, 24'h000000);
    xfer("rd2c", 8'h2C, 24'h000000);
    xfer("rd3f", 8'h3F, 24'h000000);

    s0 = strobe_cnt;
    do_frame(8'h00, 24'h000000, 20, -1, rx);
    check("short_frame_strobe", strobe_cnt - s0, 32'h0);
    xfer("ctl_wr", 8'h00, 24'h000000);
    xfer("w05", 8'h05, 24'h5A5A5A);
    xfer("w2a_blocked", 8'h2A, 24'h777777);

    xfer("swrst", 8'h00, 24'h000009);
    xfer("rd05_after_swrst", 8'h05, 24'h000000);
    xfer("rd00_after_swrst", 8'h00, 24'h000001);
    xfer("ctl_clr", 8'h00, 24'h000000);

    rdy_q.delete();
    xfer("tmr_on", 8'h1E, 24'h000100);
    sc = strobe_cyc;
    tick(30);
    check("tmr_count", {31'h0, rdy_q.size() >= 3}, 32'h1);
    if (rdy_q.size() >= 3) begin
      check("tmr_first", rdy_q[0], sc + 9);
      check("tmr_per1", rdy_q[1] - rdy_q[0], 32'd10);
      check("tmr_per2", rdy_q[2] - rdy_q[1], 32'd10);
    end
    xfer("tmr_off", 8'h1E, 24'h000000);
    rdy_q.delete();
    tick(40);
    check("tmr_quiet", rdy_q.size(), 32'h0);

    xfer("w07", 8'h07, 24'h111111);
    s0 = strobe_cnt;
    do_frame(8'h07, 24'h222222, 32, 15, rx);
    model_clear();
    check("rstmid_strobe", strobe_cnt - s0, 32'h0);
    check("rstmid_wr_addr", {24'h0, wr_addr}, 32'h0);
    check("rstmid_wr_data", {8'h0, wr_data}, 32'h0);
    xfer("w09_after_rst", 8'h09, 24'hABC123);

    for (int n = 0; n < 30; n++) begin
      sel = $urandom_range(0, 9);
      d = 24'($urandom);
      case (sel)
        0, 1: begin
          a = 8'h00;
          d = d & 24'h00FFF7;
          if ($urandom_range(0, 3) == 0) d = d | 24'h000008;
        end
        2: a = 8'h2A + 8'($urandom_range(0, 5));
        3: a = 8'($urandom_range(50, 255));
        default: a = 8'($urandom_range(1, 49));
      endcase
      xfer($sformatf("rnd%0d", n), a, d);
    end

    xfer("rb_ctl", 8'h00, 24'h000001);
    for (int i = 0; i < 64; i++) begin
      xfer($sformatf("rb%0h", i), 8'(i), (i == 0) ? 24'h000001 : 24'h000000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
